// File: rtl/axi_dma_w.sv
// AXI4 write-master DMA: accepts one burst request plus BURST_LEN+1 beats from the
// databus, issues a single INCR burst on AW/W/B and latches the write response status.
module axi_dma_w #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 15,
  parameter int ID_W      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_ready,
  output logic                o_busy,
  output logic                o_error,
  output logic [ID_W-1:0]     o_m_axi_awid,
  output logic [ADDR_W-1:0]   o_m_axi_awaddr,
  output logic [7:0]          o_m_axi_awlen,
  output logic [2:0]          o_m_axi_awsize,
  output logic [1:0]          o_m_axi_awburst,
  output logic                o_m_axi_awlock,
  output logic [3:0]          o_m_axi_awcache,
  output logic [2:0]          o_m_axi_awprot,
  output logic [3:0]          o_m_axi_awqos,
  output logic                o_m_axi_awvalid,
  input  logic                i_m_axi_awready,
  output logic [DATA_W-1:0]   o_m_axi_wdata,
  output logic [DATA_W/8-1:0] o_m_axi_wstrb,
  output logic                o_m_axi_wlast,
  output logic                o_m_axi_wvalid,
  input  logic                i_m_axi_wready,
  input  logic [ID_W-1:0]     i_m_axi_bid,
  input  logic [1:0]          i_m_axi_bresp,
  input  logic                i_m_axi_bvalid,
  output logic                o_m_axi_bready
);

  localparam int AXI_LEN_W = 8;
  localparam logic [AXI_LEN_W:0] C_LAST_BEAT = (AXI_LEN_W+1)'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_W_ADDR = 2'd1,
    S_W_DATA = 2'd2,
    S_W_RESP = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [AXI_LEN_W:0]   r_cnt;
  logic [ADDR_W-1:0]    r_awaddr;
  logic                 r_error;

  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_last_beat;
  logic w_unused_bid;

  assign w_unused_bid = ^i_m_axi_bid;

  // Handshake and channel-valid decode from the current state
  always_comb begin
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    case (r_state)
      S_IDLE:   w_awvalid = 1'b0;
      S_W_ADDR: w_awvalid = 1'b1;
      S_W_DATA: w_wvalid  = i_valid;
      S_W_RESP: w_bready  = 1'b1;
      default:  w_awvalid = 1'b0;
    endcase
    w_aw_hs     = w_awvalid & i_m_axi_awready;
    w_w_hs      = w_wvalid & i_m_axi_wready;
    w_b_hs      = w_bready & i_m_axi_bvalid;
    w_last_beat = (r_cnt == C_LAST_BEAT);
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_valid) w_next_state = S_W_ADDR;
        else         w_next_state = S_IDLE;
      end
      S_W_ADDR: begin
        if (w_aw_hs) w_next_state = S_W_DATA;
        else         w_next_state = S_W_ADDR;
      end
      S_W_DATA: begin
        if (w_w_hs && w_last_beat) w_next_state = S_W_RESP;
        else                       w_next_state = S_W_DATA;
      end
      S_W_RESP: begin
        if (w_b_hs) w_next_state = S_IDLE;
        else        w_next_state = S_W_RESP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Beat counter wraps to zero on the last beat so it never exceeds BURST_LEN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_awaddr <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_valid) r_awaddr <= i_addr;
        end
        S_W_DATA: begin
          if (w_w_hs) r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
        end
        S_W_RESP: begin
          if (w_b_hs) r_error <= (i_m_axi_bresp != 2'b00);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_ready         = w_w_hs;
  assign o_busy          = (r_state != S_IDLE);
  assign o_error         = r_error;
  assign o_m_axi_awid    = '0;
  assign o_m_axi_awaddr  = r_awaddr;
  assign o_m_axi_awlen   = 8'(BURST_LEN);
  assign o_m_axi_awsize  = 3'($clog2(DATA_W/8));
  assign o_m_axi_awburst = 2'b01;
  assign o_m_axi_awlock  = 1'b0;
  assign o_m_axi_awcache = 4'd2;
  assign o_m_axi_awprot  = 3'b010;
  assign o_m_axi_awqos   = 4'd0;
  assign o_m_axi_awvalid = w_awvalid;
  assign o_m_axi_wdata   = i_wdata;
  assign o_m_axi_wstrb   = '1;
  assign o_m_axi_wlast   = w_wvalid & w_last_beat;
  assign o_m_axi_wvalid  = w_wvalid;
  assign o_m_axi_bready  = w_bready;

endmodule

// File: tb/tb_axi_dma_w.sv
// Scoreboard bench for axi_dma_w: expected AW/W items are queued as stimulus is
// driven and popped by a negedge monitor when the DUT presents them.
module tb_axi_dma_w;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BLEN   = 15;
  localparam int ID_W   = 4;
  localparam int NBEATS = BLEN + 1;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_valid;
  logic [ADDR_W-1:0]   i_addr;
  logic [DATA_W-1:0]   i_wdata;
  logic                o_ready, o_busy, o_error;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;

  axi_dma_w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BLEN), .ID_W(ID_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_busy(o_busy), .o_error(o_error),
    .o_m_axi_awid(awid), .o_m_axi_awaddr(awaddr), .o_m_axi_awlen(awlen),
    .o_m_axi_awsize(awsize), .o_m_axi_awburst(awburst), .o_m_axi_awlock(awlock),
    .o_m_axi_awcache(awcache), .o_m_axi_awprot(awprot), .o_m_axi_awqos(awqos),
    .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
    .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast),
    .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready),
    .i_m_axi_bid(bid), .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid),
    .o_m_axi_bready(bready)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_hold_q[$];
  logic [DATA_W-1:0] exp_data_q[$];

  logic tb_data_phase = 1'b0;
  logic tb_resp_phase = 1'b0;
  logic tb_busy       = 1'b0;
  logic tb_err        = 1'b0;

  int                mon_beats = 0;
  int                aw_hold   = 0;
  logic              aw_done   = 1'b0;
  logic [ADDR_W-1:0] aw_first;

  // Monitor: every cycle compares channel controls with the bench's own phase model
  always @(negedge i_clk) begin
    if (i_rst) begin
      mon_beats = 0;
      aw_hold   = 0;
      aw_done   = 1'b0;
    end else begin
      if (awvalid) begin
        if (aw_hold == 0) aw_first = awaddr;
        else check_eq("awaddr_stable", awaddr, aw_first);
        aw_hold++;
        if (awready) begin
          if (exp_addr_q.size() == 0) check_eq("aw_unexpected", 1, 0);
          else begin
            check_eq("awaddr", awaddr, exp_addr_q.pop_front());
            check_eq("aw_hold_cycles", aw_hold, exp_hold_q.pop_front());
            check_eq("awlen", awlen, 8'd15);
            check_eq("awsize", awsize, 3'd3);
            check_eq("aw_consts", {awid, awburst, awlock, awcache, awprot, awqos, wstrb},
                     {4'd0, 2'b01, 1'b0, 4'd2, 3'b010, 4'd0, 8'hFF});
          end
          aw_hold = 0;
          aw_done = 1'b1;
        end
      end
      if (wvalid && !aw_done) check_eq("w_before_aw", 1, 0);
      check_eq("wvalid", wvalid, tb_data_phase & i_valid);
      check_eq("ready", o_ready, tb_data_phase & i_valid & wready);
      check_eq("wlast", wlast, tb_data_phase & i_valid & (mon_beats == BLEN));
      check_eq("bready", bready, tb_resp_phase);
      check_eq("busy", o_busy, tb_busy);
      if (wvalid && wready) begin
        if (exp_data_q.size() == 0) check_eq("w_unexpected", 1, 0);
        else check_eq("wdata", wdata, exp_data_q.pop_front());
        mon_beats = (mon_beats == BLEN) ? 0 : mon_beats + 1;
      end
      if (bready && bvalid) aw_done = 1'b0;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] addr, input logic [1:0] resp,
                           input int aw_delay, input int b_delay, input bit rnd,
                           input int abort_at);
    logic [DATA_W-1:0] beats[NBEATS];
    int idx, guard;
    bit hs;
    for (int i = 0; i < NBEATS; i++) beats[i] = {$urandom(), $urandom()};
    i_valid = 1'b1;
    i_addr  = addr;
    exp_addr_q.push_back(addr);
    exp_hold_q.push_back(aw_delay + 1);
    @(negedge i_clk);
    check_eq("error_held_at_req", o_error, tb_err);
    step();
    tb_busy = 1'b1;
    i_wdata = ~beats[0];
    for (int k = 0; k <= aw_delay; k++) begin
      awready = (k == aw_delay);
      wready  = 1'b1;
      step();
    end
    awready = 1'b0;
    tb_data_phase = 1'b1;
    for (int i = 0; i < NBEATS; i++) exp_data_q.push_back(beats[i]);
    idx = 0;
    guard = 0;
    while (idx < NBEATS && guard < 1000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        i_rst = 1'b1;
        i_valid = 1'b0;
        wready = 1'b0;
        tb_data_phase = 1'b0;
        tb_busy = 1'b0;
        step();
        i_rst = 1'b0;
        exp_data_q.delete();
        tb_err = 1'b0;
        @(negedge i_clk);
        check_eq("rst_outputs", {awvalid, wvalid, bready, o_ready, o_busy, o_error}, 6'd0);
        step();
        return;
      end
      i_wdata = beats[idx];
      i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bresp   = 2'b10;
      hs = i_valid & wready;
      step();
      if (hs) idx++;
      guard++;
    end
    if (idx < NBEATS) check_eq("data_timeout", idx, NBEATS);
    tb_data_phase = 1'b0;
    tb_resp_phase = 1'b1;
    i_valid = 1'b1;
    wready  = 1'b1;
    for (int k = 0; k <= b_delay; k++) begin
      bvalid = (k == b_delay);
      bresp  = (k == b_delay) ? resp : 2'b11;
      step();
    end
    bvalid = 1'b0;
    i_valid = 1'b0;
    tb_resp_phase = 1'b0;
    tb_busy = 1'b0;
    tb_err = (resp != 2'b00);
    @(negedge i_clk);
    check_eq("error_after_b", o_error, tb_err);
    check_eq("no_beats_left", exp_data_q.size(), 0);
    step();
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_wdata = '0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("reset_state", {awvalid, wvalid, bready, o_ready, o_busy, o_error}, 6'd0);
    check_eq("reset_awaddr", awaddr, 32'd0);
    step();
    run_burst(32'h0000_0100, 2'b00, 0, 0, 1'b0, -1);
    run_burst(32'h0000_2000, 2'b00, 5, 0, 1'b0, -1);
    run_burst(32'h0000_3040, 2'b00, 1, 2, 1'b1, -1);
    run_burst(32'h0000_4000, 2'b10, 0, 1, 1'b0, -1);
    run_burst(32'h0000_5000, 2'b00, 2, 0, 1'b0, -1);
    run_burst(32'h0000_6000, 2'b10, 0, 0, 1'b0, -1);
    run_burst(32'h0000_7000, 2'b00, 0, 0, 1'b0, 7);
    run_burst(32'h0000_8000, 2'b00, 0, 0, 1'b0, -1);
    run_burst(32'h0000_9000, 2'b00, 0, 10, 1'b0, -1);
    run_burst(32'h0000_A000, 2'b00, 3, 4, 1'b1, -1);
    repeat (3) step();
    check_eq("aw_queue_drained", exp_addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
